qracc_sram_bus_adapter: RTL and testbench

//  Bridges the 32-bit-style generic control/data bus (valid/ready, word-addressed) onto the row-wide
//  CIM SRAM request port (rq_valid/rq_ready/rd_valid). Packs BUS_WIDTH words into NUM_COLS-wide rows
//  for writes, holds a 1-row read cache for word-granular reads, and flags protocol errors.

---
 rtl/qracc_pkg.sv | 19 +
 rtl/qracc_row_packer.sv | 49 ++++
 rtl/qracc_sram_bus_adapter.sv | 166 ++++++++++++++++
 tb/tb_qracc_sram_bus_adapter.sv | 335 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/qracc_pkg.sv
// Shared types for the QRAcc SRAM-side blocks.
// Latency: n/a. Backpressure: n/a.
// Holds the bus-adapter FSM encoding and a width helper.
package qracc_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR_REQ,
        S_RD_REQ,
        S_RD_WAIT,
        S_RESP
    } qracc_sram_adapter_state_t;

    // Word-index width; a single-word row still needs a 1-bit index.
    function automatic int widx_width(input int wpr);
        return (wpr > 1) ? $clog2(wpr) : 1;
    endfunction

endpackage

// File: rtl/qracc_row_packer.sv
// Gathers bus words into one SRAM row, tracking fill mask and pending row.
// Latency: word stored the cycle after wr_en; full/conflict are combinational on wr_en.
// Backpressure: none; the parent stops issuing wr_en while a full row is being flushed.
module qracc_row_packer
    import qracc_pkg::*;
#(
    parameter int BUS_WIDTH = 32,
    parameter int NUM_COLS  = 256,
    parameter int ROW_W     = 7,
    localparam int WPR      = NUM_COLS / BUS_WIDTH,
    localparam int WIDX_W   = widx_width(WPR)
) (
    input  logic                 clk,
    input  logic                 nrst,
    input  logic                 wr_en,
    input  logic [WIDX_W-1:0]    widx,
    input  logic [ROW_W-1:0]     row,
    input  logic [BUS_WIDTH-1:0] data,
    output logic [NUM_COLS-1:0]  row_data,
    output logic [ROW_W-1:0]     pend_row,
    output logic                 full,
    output logic                 conflict
);

    logic [WPR-1:0] mask;
    logic [WPR-1:0] mask_base;
    logic [WPR-1:0] mask_set;

    always_comb begin
        conflict  = wr_en && (mask != '0) && (row != pend_row);
        // A write to a different row throws away the partial row gathered so far.
        mask_base = conflict ? '0 : mask;
        mask_set  = mask_base | (WPR'(1) << widx);
        full      = wr_en && (mask_set == {WPR{1'b1}});
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            row_data <= '0;
            mask     <= '0;
            pend_row <= '0;
        end else if (wr_en) begin
            row_data[int'(widx)*BUS_WIDTH +: BUS_WIDTH] <= data;
            mask     <= full ? '0 : mask_set;
            pend_row <= row;
        end
    end

endmodule

// File: rtl/qracc_sram_bus_adapter.sv
// Bridges the word-addressed bus onto the row-wide CIM SRAM port with write packing and a 1-row read cache.
// Latency: read hit 1 cycle after accept, miss SRAM latency + 2; writes flush one cycle after the row fills.
// Backpressure: bus_ready_o only in IDLE (one request outstanding); SRAM requests held until sram_rq_ready_i.
module qracc_sram_bus_adapter
    import qracc_pkg::*;
#(
    parameter int BUS_WIDTH  = 32,
    parameter int NUM_ROWS   = 128,
    parameter int NUM_COLS   = 256,
    parameter int ADDR_WIDTH = 32,
    localparam int WPR       = NUM_COLS / BUS_WIDTH,
    localparam int WIDX_W    = widx_width(WPR),
    localparam int ROW_W     = $clog2(NUM_ROWS)
) (
    input  logic                  clk,
    input  logic                  nrst,
    input  logic                  bus_valid_i,
    output logic                  bus_ready_o,
    input  logic                  bus_wen_i,
    input  logic [ADDR_WIDTH-1:0] bus_addr_i,
    input  logic [BUS_WIDTH-1:0]  bus_data_i,
    output logic [BUS_WIDTH-1:0]  bus_rdata_o,
    output logic                  bus_rdata_valid_o,
    output logic                  sram_rq_valid_o,
    output logic                  sram_rq_wr_o,
    input  logic                  sram_rq_ready_i,
    output logic [ROW_W-1:0]      sram_addr_o,
    output logic [NUM_COLS-1:0]   sram_wr_data_o,
    input  logic                  sram_rd_valid_i,
    input  logic [NUM_COLS-1:0]   sram_rd_data_i,
    output logic                  err_o,
    input  logic                  err_clr_i
);

    qracc_sram_adapter_state_t state, state_nxt;

    logic                 run;
    logic [WIDX_W-1:0]    a_widx;
    logic [ROW_W-1:0]     a_row;
    logic                 a_oor;
    logic                 accept;
    logic                 wr_acc;
    logic                 rd_acc;
    logic                 hit;
    logic                 err_set;
    logic                 pk_full;
    logic                 pk_conflict;
    logic [ROW_W-1:0]     pend_row;
    logic [ROW_W-1:0]     req_row;
    logic [WIDX_W-1:0]    req_widx;
    logic                 cache_vld;
    logic [ROW_W-1:0]     cache_tag;
    logic [NUM_COLS-1:0]  cache_row;

    assign a_widx = bus_addr_i[WIDX_W-1:0];
    assign a_row  = bus_addr_i[WIDX_W +: ROW_W];
    // Bits above {row, widx}, or a row/word index past the array edge, are out of range.
    assign a_oor  = ((bus_addr_i >> (WIDX_W + ROW_W)) != '0)
                 || (int'(a_row) >= NUM_ROWS)
                 || (int'(a_widx) >= WPR);

    assign bus_ready_o = run && (state == S_IDLE);
    assign accept      = bus_valid_i && bus_ready_o;
    assign wr_acc      = accept && bus_wen_i && !a_oor;
    assign rd_acc      = accept && !bus_wen_i;
    assign hit         = cache_vld && (cache_tag == a_row);

    qracc_row_packer #(
        .BUS_WIDTH (BUS_WIDTH),
        .NUM_COLS  (NUM_COLS),
        .ROW_W     (ROW_W)
    ) u_packer (
        .clk       (clk),
        .nrst      (nrst),
        .wr_en     (wr_acc),
        .widx      (a_widx),
        .row       (a_row),
        .data      (bus_data_i),
        .row_data  (sram_wr_data_o),
        .pend_row  (pend_row),
        .full      (pk_full),
        .conflict  (pk_conflict)
    );

    always_comb begin
        state_nxt         = state;
        err_set           = 1'b0;
        sram_rq_valid_o   = 1'b0;
        sram_rq_wr_o      = 1'b0;
        sram_addr_o       = '0;
        bus_rdata_valid_o = 1'b0;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    if (a_oor) begin
                        err_set = 1'b1;
                        if (!bus_wen_i) state_nxt = S_RESP;
                    end else if (bus_wen_i) begin
                        err_set = pk_conflict;
                        if (pk_full) state_nxt = S_WR_REQ;
                    end else begin
                        state_nxt = hit ? S_RESP : S_RD_REQ;
                    end
                end
            end
            S_WR_REQ: begin
                sram_rq_valid_o = 1'b1;
                sram_rq_wr_o    = 1'b1;
                sram_addr_o     = pend_row;
                if (sram_rq_ready_i) state_nxt = S_IDLE;
            end
            S_RD_REQ: begin
                sram_rq_valid_o = 1'b1;
                sram_addr_o     = req_row;
                if (sram_rq_ready_i) state_nxt = S_RD_WAIT;
            end
            S_RD_WAIT: begin
                if (sram_rd_valid_i) state_nxt = S_RESP;
            end
            S_RESP: begin
                bus_rdata_valid_o = 1'b1;
                state_nxt         = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
        if (sram_rd_valid_i && (state != S_RD_WAIT)) err_set = 1'b1;
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state       <= S_IDLE;
            run         <= 1'b0;
            err_o       <= 1'b0;
            req_row     <= '0;
            req_widx    <= '0;
            cache_vld   <= 1'b0;
            cache_tag   <= '0;
            cache_row   <= '0;
            bus_rdata_o <= '0;
        end else begin
            state <= state_nxt;
            run   <= 1'b1;
            if (err_set) err_o <= 1'b1;
            else if (err_clr_i) err_o <= 1'b0;

            if (rd_acc) begin
                req_row  <= a_row;
                req_widx <= a_widx;
                if (a_oor) bus_rdata_o <= '0;
                else if (hit) bus_rdata_o <= cache_row[int'(a_widx)*BUS_WIDTH +: BUS_WIDTH];
            end

            if ((state == S_RD_WAIT) && sram_rd_valid_i) begin
                cache_row   <= sram_rd_data_i;
                cache_tag   <= req_row;
                cache_vld   <= 1'b1;
                bus_rdata_o <= sram_rd_data_i[int'(req_widx)*BUS_WIDTH +: BUS_WIDTH];
            end

            // A flushed row that matches the cached one makes the cache stale.
            if ((state == S_WR_REQ) && sram_rq_ready_i && (cache_tag == pend_row))
                cache_vld <= 1'b0;
        end
    end

endmodule

// File: tb/tb_qracc_sram_bus_adapter.sv
// Bench for qracc_sram_bus_adapter: vector table plus hand sequences, SRAM model with latency 2.
module tb_qracc_sram_bus_adapter;
    localparam int BW = 32;
    localparam int NR = 4;
    localparam int NC = 64;
    localparam int AW = 32;
    localparam int RW = 2;

    logic          clk = 1'b0;
    logic          nrst = 1'b0;
    logic          bus_valid_i = 1'b0;
    logic          bus_ready_o;
    logic          bus_wen_i = 1'b0;
    logic [AW-1:0] bus_addr_i = '0;
    logic [BW-1:0] bus_data_i = '0;
    logic [BW-1:0] bus_rdata_o;
    logic          bus_rdata_valid_o;
    logic          sram_rq_valid_o;
    logic          sram_rq_wr_o;
    logic          sram_rq_ready_i;
    logic [RW-1:0] sram_addr_o;
    logic [NC-1:0] sram_wr_data_o;
    logic          sram_rd_valid_i;
    logic [NC-1:0] sram_rd_data_i;
    logic          err_o;
    logic          err_clr_i = 1'b0;
    logic          model_rd_vld;
    logic          stray_vld = 1'b0;

    assign sram_rd_valid_i = model_rd_vld | stray_vld;

    always #5 clk = ~clk;

    qracc_sram_bus_adapter #(
        .BUS_WIDTH(BW), .NUM_ROWS(NR), .NUM_COLS(NC), .ADDR_WIDTH(AW)
    ) dut (
        .clk(clk), .nrst(nrst),
        .bus_valid_i(bus_valid_i), .bus_ready_o(bus_ready_o), .bus_wen_i(bus_wen_i),
        .bus_addr_i(bus_addr_i), .bus_data_i(bus_data_i),
        .bus_rdata_o(bus_rdata_o), .bus_rdata_valid_o(bus_rdata_valid_o),
        .sram_rq_valid_o(sram_rq_valid_o), .sram_rq_wr_o(sram_rq_wr_o),
        .sram_rq_ready_i(sram_rq_ready_i), .sram_addr_o(sram_addr_o),
        .sram_wr_data_o(sram_wr_data_o), .sram_rd_valid_i(sram_rd_valid_i),
        .sram_rd_data_i(sram_rd_data_i), .err_o(err_o), .err_clr_i(err_clr_i)
    );

    int cyc = 0;
    always @(posedge clk) cyc++;

    // Response monitor: logs every rdata pulse with the cycle it was seen in.
    logic [BW-1:0] obs_dat [0:255];
    int            obs_n = 0;
    int            last_rsp_cyc = -100;
    always @(negedge clk) begin
        if (bus_rdata_valid_o && obs_n < 256) begin
            obs_dat[obs_n] = bus_rdata_o;
            obs_n++;
            last_rsp_cyc = cyc;
        end
    end

    // SRAM model: read data two cycles after the request handshake.
    logic [NC-1:0] mem [0:NR-1];
    logic [RW-1:0] wlog_row [0:63];
    logic [NC-1:0] wlog_dat [0:63];
    logic [RW-1:0] rd_row;
    int n_wr = 0;
    int n_rd = 0;
    int rd_cnt = 0;
    int rdy_mode = 0;   // 0 random, 1 always ready, 2 never ready
    initial begin
        for (int r = 0; r < NR; r++)
            mem[r] = {32'hC0DE_0001 + 32'(2*r), 32'hC0DE_0000 + 32'(2*r)};
        sram_rq_ready_i = 1'b0;
        model_rd_vld    = 1'b0;
        sram_rd_data_i  = '0;
        rd_row          = '0;
        forever begin
            @(negedge clk);
            model_rd_vld = 1'b0;
            if (rd_cnt > 0) begin
                rd_cnt--;
                if (rd_cnt == 0) begin
                    model_rd_vld   = 1'b1;
                    sram_rd_data_i = mem[rd_row];
                end
            end
            case (rdy_mode)
                0:       sram_rq_ready_i = 1'($urandom_range(0, 1));
                1:       sram_rq_ready_i = 1'b1;
                default: sram_rq_ready_i = 1'b0;
            endcase
            if (nrst && sram_rq_valid_o && sram_rq_ready_i) begin
                if (sram_rq_wr_o) begin
                    mem[sram_addr_o] = sram_wr_data_o;
                    if (n_wr < 64) begin
                        wlog_row[n_wr] = sram_addr_o;
                        wlog_dat[n_wr] = sram_wr_data_o;
                    end
                    n_wr++;
                end else begin
                    rd_row = sram_addr_o;
                    rd_cnt = 2;
                    n_rd++;
                end
            end
        end
    end

    int total = 0;
    int bad = 0;
    logic [BW-1:0] exp_q [$];
    logic [RW+NC-1:0] wexp_q [$];
    int obs_rd = 0;
    int wchk = 0;

    task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail(input string name);
        total++;
        bad++;
        $display("FAIL %s: got none, expected event", name);
    endtask

    task automatic bus_op(input logic wen, input logic [AW-1:0] addr, input logic [BW-1:0] data,
                          output int acc);
        int n = 0;
        bus_valid_i = 1'b1;
        bus_wen_i   = wen;
        bus_addr_i  = addr;
        bus_data_i  = data;
        while (!bus_ready_o && n < 100) begin
            @(negedge clk); #1;
            n++;
        end
        if (n >= 100) fail("accept_timeout");
        acc = cyc;
        @(negedge clk); #1;
        bus_valid_i = 1'b0;
    endtask

    task automatic settle();
        int n = 0;
        while (!bus_ready_o && n < 100) begin
            @(negedge clk); #1;
            n++;
        end
        if (n >= 100) fail("settle_timeout");
    endtask

    task automatic drain();
        while (obs_rd < obs_n) begin
            if (exp_q.size() == 0) fail("unexpected_rsp");
            else chk("rdata", 96'(obs_dat[obs_rd]), 96'(exp_q.pop_front()));
            obs_rd++;
        end
        if (exp_q.size() != 0) begin
            fail("missing_rsp");
            exp_q.delete();
        end
        while (wchk < n_wr) begin
            if (wexp_q.size() == 0) fail("unexpected_sram_wr");
            else chk("sram_wr", 96'({wlog_row[wchk], wlog_dat[wchk]}), 96'(wexp_q.pop_front()));
            wchk++;
        end
        if (wexp_q.size() != 0) begin
            fail("missing_sram_wr");
            wexp_q.delete();
        end
    endtask

    task automatic clr_err();
        err_clr_i = 1'b1;
        @(negedge clk); #1;
        err_clr_i = 1'b0;
        chk("err_clr", 96'(err_o), 96'd0);
    endtask

    typedef struct {
        logic          wen;
        logic [AW-1:0] addr;
        logic [BW-1:0] data;     // write data, or expected read data
        logic          exp_err;
        logic          clr;
        logic          exp_w;
        logic [RW-1:0] w_row;
        logic [NC-1:0] w_dat;
    } vec_t;

    localparam int NV = 18;
    vec_t vec [NV];

    initial begin
        int acc;
        int nrd0;
        int nwr0;

        vec[0]  = '{1'b1, 32'd2, 32'hAAAA_0000, 1'b0, 1'b0, 1'b0, 2'd0, 64'd0};
        vec[1]  = '{1'b1, 32'd3, 32'hBBBB_1111, 1'b0, 1'b0, 1'b1, 2'd1, 64'hBBBB_1111_AAAA_0000};
        vec[2]  = '{1'b0, 32'd3, 32'hBBBB_1111, 1'b0, 1'b0, 1'b0, 2'd0, 64'd0};
        vec[3]  = '{1'b0, 32'd2, 32'hAAAA_0000, 1'b0, 1'b0, 1'b0, 2'd0, 64'd0};
        vec[4]  = '{1'b1, 32'd2, 32'h1111_2222, 1'b0, 1'b0, 1'b0, 2'd0, 64'd0};
        vec[5]  = '{1'b1, 32'd4, 32'h3333_4444, 1'b1, 1'b1, 1'b0, 2'd0, 64'd0};
        vec[6]  = '{1'b1, 32'd5, 32'h5555_6666, 1'b0, 1'b0, 1'b1, 2'd2, 64'h5555_6666_3333_4444};
        vec[7]  = '{1'b0, 32'd4, 32'h3333_4444, 1'b0, 1'b0, 1'b0, 2'd0, 64'd0};
        vec[8]  = '{1'b0, 32'd3, 32'hBBBB_1111, 1'b0, 1'b0, 1'b0, 2'd0, 64'd0};
        vec[9]  = '{1'b1, 32'd2, 32'h0000_0001, 1'b0, 1'b0, 1'b0, 2'd0, 64'd0};
        vec[10] = '{1'b1, 32'd3, 32'h0000_0002, 1'b0, 1'b0, 1'b1, 2'd1, 64'h0000_0002_0000_0001};
        vec[11] = '{1'b0, 32'd2, 32'h0000_0001, 1'b0, 1'b0, 1'b0, 2'd0, 64'd0};
        vec[12] = '{1'b0, 32'd1, 32'hC0DE_0001, 1'b0, 1'b0, 1'b0, 2'd0, 64'd0};
        vec[13] = '{1'b1, 32'd6, 32'hDEAD_0001, 1'b0, 1'b0, 1'b0, 2'd0, 64'd0};
        vec[14] = '{1'b1, 32'd6, 32'hDEAD_0002, 1'b0, 1'b0, 1'b0, 2'd0, 64'd0};
        vec[15] = '{1'b1, 32'd7, 32'hDEAD_0003, 1'b0, 1'b0, 1'b1, 2'd3, 64'hDEAD_0003_DEAD_0002};
        vec[16] = '{1'b0, 32'd7, 32'hDEAD_0003, 1'b0, 1'b0, 1'b0, 2'd0, 64'd0};
        vec[17] = '{1'b0, 32'd6, 32'hDEAD_0002, 1'b0, 1'b0, 1'b0, 2'd0, 64'd0};

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        chk("rst_bus_ready", 96'(bus_ready_o), 96'd0);
        chk("rst_rq_valid", 96'(sram_rq_valid_o), 96'd0);
        chk("rst_rq_wr", 96'(sram_rq_wr_o), 96'd0);
        chk("rst_rdata_valid", 96'(bus_rdata_valid_o), 96'd0);
        chk("rst_rdata", 96'(bus_rdata_o), 96'd0);
        chk("rst_err", 96'(err_o), 96'd0);
        chk("rst_wr_data", 96'(sram_wr_data_o), 96'd0);
        nrst = 1'b1;
        @(negedge clk); #1;
        chk("ready_after_rst", 96'(bus_ready_o), 96'd1);

        // Vector table, random SRAM ready
        for (int i = 0; i < NV; i++) begin
            if (!vec[i].wen) exp_q.push_back(vec[i].data);
            if (vec[i].exp_w) wexp_q.push_back({vec[i].w_row, vec[i].w_dat});
            bus_op(vec[i].wen, vec[i].addr, vec[i].data, acc);
            settle();
            drain();
            chk($sformatf("v%0d_err", i), 96'(err_o), 96'(vec[i].exp_err));
            if (vec[i].clr) clr_err();
        end

        // Exact miss / hit latency with SRAM always ready
        rdy_mode = 1;
        @(negedge clk); #1;
        nrd0 = n_rd;
        exp_q.push_back(32'h0000_0001);
        bus_op(1'b0, 32'd2, 32'd0, acc);
        settle();
        chk("miss_latency", 96'(last_rsp_cyc - acc), 96'd4);
        chk("miss_rq_count", 96'(n_rd - nrd0), 96'd1);
        drain();
        nrd0 = n_rd;
        exp_q.push_back(32'h0000_0002);
        bus_op(1'b0, 32'd3, 32'd0, acc);
        settle();
        chk("hit_latency", 96'(last_rsp_cyc - acc), 96'd1);
        chk("hit_rq_count", 96'(n_rd - nrd0), 96'd0);
        drain();
        @(negedge clk); #1;
        chk("rdata_hold", 96'(bus_rdata_o), 96'h0000_0002);
        chk("rdata_valid_low", 96'(bus_rdata_valid_o), 96'd0);

        // Out-of-range read and write
        nrd0 = n_rd;
        nwr0 = n_wr;
        exp_q.push_back(32'h0);
        bus_op(1'b0, 32'd8, 32'd0, acc);
        settle();
        chk("oor_latency", 96'(last_rsp_cyc - acc), 96'd1);
        chk("oor_rd_err", 96'(err_o), 96'd1);
        drain();
        clr_err();
        bus_op(1'b1, 32'd9, 32'hFFFF_FFFF, acc);
        settle();
        chk("oor_wr_err", 96'(err_o), 96'd1);
        chk("oor_no_sram", 96'((n_rd - nrd0) + (n_wr - nwr0)), 96'd0);
        clr_err();

        // Stray read data, and set beating clear in the same cycle
        stray_vld = 1'b1;
        @(negedge clk); #1;
        stray_vld = 1'b0;
        chk("stray_err", 96'(err_o), 96'd1);
        clr_err();
        stray_vld = 1'b1;
        err_clr_i = 1'b1;
        @(negedge clk); #1;
        stray_vld = 1'b0;
        err_clr_i = 1'b0;
        chk("set_wins_clr", 96'(err_o), 96'd1);
        clr_err();

        // Reset while a row write is held in WR_REQ
        rdy_mode = 2;
        @(negedge clk); #1;
        bus_op(1'b1, 32'd0, 32'h7777_0000, acc);
        bus_op(1'b1, 32'd1, 32'h7777_0001, acc);
        @(negedge clk); #1;
        chk("wrreq_held", 96'({sram_rq_valid_o, sram_rq_wr_o}), 96'd3);
        nrst = 1'b0;
        #1;
        chk("rst_drops_rq", 96'(sram_rq_valid_o), 96'd0);
        chk("rst_drops_ready", 96'(bus_ready_o), 96'd0);
        @(negedge clk); #1;
        nrst = 1'b1;
        rdy_mode = 0;
        @(negedge clk); #1;
        settle();
        nrd0 = n_rd;
        exp_q.push_back(32'h0000_0001);
        bus_op(1'b0, 32'd2, 32'd0, acc);
        settle();
        exp_q.push_back(32'hC0DE_0000);
        bus_op(1'b0, 32'd0, 32'd0, acc);
        settle();
        drain();
        chk("post_rst_misses", 96'(n_rd - nrd0), 96'd2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, expected finish before 200000");
        $fatal(1);
    end

endmodule
